spiflash_rsp: RTL

SPIFLASH_RSP -- requirements
Module: spiflash_rsp

---
 rtl/spiflash_pkg.sv | 34 +++
 rtl/spiflash_sync.sv | 60 ++++++
 rtl/spiflash_rsp.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spiflash_pkg.sv
// +---------------------------------------------------------------------------+
// | spiflash_pkg: opcodes, FSM states and output-enable patterns shared by    |
// | the SPI flash responder.                                    Rev 1.0       |
// +---------------------------------------------------------------------------+
`default_nettype none

package spiflash_pkg;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_QREAD   = 8'hEB;
  localparam logic [7:0] OP_RES     = 8'hAB;
  localparam logic [7:0] OP_DP      = 8'hB9;
  localparam logic [7:0] OP_RST_CRM = 8'hFF;

  // mode[5:4] value that keeps the part in continuous quad read
  localparam logic [1:0] CONT_MODE = 2'b10;

  localparam logic [3:0] OE_OFF    = 4'b0000;
  localparam logic [3:0] OE_SINGLE = 4'b0010;
  localparam logic [3:0] OE_QUAD   = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MODE   = 3'd3,
    ST_DUMMY  = 3'd4,
    ST_DATA   = 3'd5,
    ST_IGNORE = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spiflash_sync.sv
// +---------------------------------------------------------------------------+
// | spiflash_sync: 2-flop synchronizers for CSB/SCK/IO plus SCK edge detect.  |
// |                                                             Rev 1.0       |
// +---------------------------------------------------------------------------+
`default_nettype none

module spiflash_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       flash_csb,
  input  logic       flash_clk,
  input  logic [3:0] flash_di,
  output logic       csb_s,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic [3:0] di_s
);

  logic       csb_meta_q, csb_meta_d, csb_sync_q, csb_sync_d;
  logic       sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic [3:0] di_meta_q, di_meta_d, di_sync_q, di_sync_d;

  always_comb begin
    csb_meta_d = flash_csb;
    csb_sync_d = csb_meta_q;
    sck_meta_d = flash_clk;
    sck_sync_d = sck_meta_q;
    sck_prev_d = sck_sync_q;
    di_meta_d  = flash_di;
    di_sync_d  = di_meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csb_meta_q <= 1'b1;
      csb_sync_q <= 1'b1;
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_prev_q <= 1'b0;
      di_meta_q  <= 4'h0;
      di_sync_q  <= 4'h0;
    end else begin
      csb_meta_q <= csb_meta_d;
      csb_sync_q <= csb_sync_d;
      sck_meta_q <= sck_meta_d;
      sck_sync_q <= sck_sync_d;
      sck_prev_q <= sck_prev_d;
      di_meta_q  <= di_meta_d;
      di_sync_q  <= di_sync_d;
    end
  end

  assign csb_s    = csb_sync_q;
  assign di_s     = di_sync_q;
  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;

endmodule

`default_nettype wire

// File: rtl/spiflash_rsp.sv
// +---------------------------------------------------------------------------+
// | spiflash_rsp: SPI NOR flash responder backed by a byte memory port.       |
// | Quad read (0xEB) with continuous mode is built only with QUAD_READ_EN.    |
// |                                                             Rev 1.0       |
// +---------------------------------------------------------------------------+
`default_nettype none

module spiflash_rsp
  import spiflash_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DUMMY_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic [3:0]        flash_di,
  output logic [3:0]        flash_do,
  output logic [3:0]        flash_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata
);

  logic       csb_s, sck_rise, sck_fall;
  logic [3:0] di_s;

  spiflash_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_di  (flash_di),
    .csb_s     (csb_s),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .di_s      (di_s)
  );

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        cmd_sr_q, cmd_sr_d;
  logic [22:0]       addr_sr_q, addr_sr_d;
  logic [7:0]        data_sr_q, data_sr_d;
  logic              pd_q, pd_d;
  logic              last_q, last_d;
  logic [3:0]        flash_do_q, flash_do_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rdata_vld_q, rdata_vld_d;

  logic              quad;
  logic [7:0]        cmd_next;
  logic [23:0]       addr_next;
  logic [7:0]        cur_byte;
  logic              byte_end;

`ifdef QUAD_READ_EN
  logic       quad_q, quad_d, cont_q, cont_d;
  logic [1:0] mode_hi_q, mode_hi_d;
  assign quad = quad_q;
`else
  assign quad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_sr_d    = cmd_sr_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    pd_d        = pd_q;
    last_d      = last_q;
    flash_do_d  = flash_do_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    rdata_vld_d = mem_rd_q;
    byte_end    = 1'b0;
`ifdef QUAD_READ_EN
    quad_d      = quad_q;
    cont_d      = cont_q;
    mode_hi_d   = mode_hi_q;
`endif
    cmd_next  = {cmd_sr_q, di_s[0]};
    addr_next = quad ? {addr_sr_q[19:0], di_s} : {addr_sr_q, di_s[0]};
    // Read data lands just as the first SCK fall may arrive, so bypass it
    cur_byte  = rdata_vld_q ? mem_rdata : data_sr_q;
    if (rdata_vld_q) data_sr_d = mem_rdata;

    // CSB high wins over any coincident SCK edge
    if (csb_s) begin
      state_d    = ST_IDLE;
      cnt_d      = 8'd0;
      last_d     = 1'b0;
      flash_do_d = 4'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = 8'd0;
          state_d = ST_CMD;
`ifdef QUAD_READ_EN
          if (cont_q) begin
            state_d = ST_ADDR;
            quad_d  = 1'b1;
          end
`endif
        end
        ST_CMD: if (sck_rise) begin
          cmd_sr_d = cmd_next[6:0];
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'd0;
            state_d = ST_IGNORE;
            if (cmd_next == OP_RES) begin
              pd_d = 1'b0;
            end else if (!pd_q) begin
              unique case (cmd_next)
                OP_READ: begin
                  state_d = ST_ADDR;
`ifdef QUAD_READ_EN
                  quad_d  = 1'b0;
`endif
                end
                OP_DP: pd_d = 1'b1;
`ifdef QUAD_READ_EN
                OP_QREAD: begin
                  state_d = ST_ADDR;
                  quad_d  = 1'b1;
                end
                OP_RST_CRM: cont_d = 1'b0;
`endif
                default: ;
              endcase
            end
          end
        end
        ST_ADDR: if (sck_rise) begin
          addr_sr_d = addr_next[22:0];
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == (quad ? 8'd5 : 8'd23)) begin
            cnt_d      = 8'd0;
            last_d     = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = ADDR_W'(addr_next);
            state_d    = quad ? ST_MODE : ST_DATA;
          end
        end
`ifdef QUAD_READ_EN
        ST_MODE: if (sck_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd0) begin
            mode_hi_d = di_s[1:0];
          end else begin
            cont_d  = (mode_hi_q == CONT_MODE);
            cnt_d   = 8'd0;
            state_d = (DUMMY_CYC == 0) ? ST_DATA : ST_DUMMY;
          end
        end
        ST_DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DUMMY_CYC - 1)) begin
            cnt_d   = 8'd0;
            state_d = ST_DATA;
          end
        end
`endif
        ST_DATA: begin
          if (sck_fall) begin
            if (quad) begin
              flash_do_d = cur_byte[7:4];
              data_sr_d  = {cur_byte[3:0], 4'h0};
              byte_end   = (cnt_q == 8'd1);
            end else begin
              flash_do_d = {2'b00, cur_byte[7], 1'b0};
              data_sr_d  = {cur_byte[6:0], 1'b0};
              byte_end   = (cnt_q == 8'd7);
            end
            cnt_d  = byte_end ? 8'd0 : cnt_q + 8'd1;
            last_d = byte_end;
          end else if (sck_rise && last_q) begin
            // Master has sampled the final bit: prefetch the following byte
            last_d     = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      cmd_sr_q    <= 7'd0;
      addr_sr_q   <= 23'd0;
      data_sr_q   <= 8'd0;
      pd_q        <= 1'b0;
      last_q      <= 1'b0;
      flash_do_q  <= 4'h0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rdata_vld_q <= 1'b0;
`ifdef QUAD_READ_EN
      quad_q      <= 1'b0;
      cont_q      <= 1'b0;
      mode_hi_q   <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      pd_q        <= pd_d;
      last_q      <= last_d;
      flash_do_q  <= flash_do_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rdata_vld_q <= rdata_vld_d;
`ifdef QUAD_READ_EN
      quad_q      <= quad_d;
      cont_q      <= cont_d;
      mode_hi_q   <= mode_hi_d;
`endif
    end
  end

  always_comb begin
    flash_oe = OE_OFF;
    if (state_q == ST_DATA) flash_oe = quad ? OE_QUAD : OE_SINGLE;
  end

  assign flash_do = flash_do_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule

`default_nettype wire
